// File: rtl/receiver_failsafe_if.sv
// Bundles the raw pwm lines, decoded channel values and gated outputs
// exchanged between the receiver, receiver_failsafe and angle_controller.
interface receiver_failsafe_if #(
    parameter int W = 8
);
    logic         throttle_pwm;
    logic         yaw_pwm;
    logic         roll_pwm;
    logic         pitch_pwm;
    logic [W-1:0] throttle_val;
    logic [W-1:0] yaw_val;
    logic [W-1:0] roll_val;
    logic [W-1:0] pitch_val;
    logic [W-1:0] throttle_out;
    logic [W-1:0] yaw_out;
    logic [W-1:0] roll_out;
    logic [W-1:0] pitch_out;
    logic         armed;
    logic         failsafe;
    logic         link_ok;

    modport master (
        output throttle_pwm, yaw_pwm, roll_pwm, pitch_pwm,
        output throttle_val, yaw_val, roll_val, pitch_val,
        input  throttle_out, yaw_out, roll_out, pitch_out,
        input  armed, failsafe, link_ok
    );

    modport slave (
        input  throttle_pwm, yaw_pwm, roll_pwm, pitch_pwm,
        input  throttle_val, yaw_val, roll_val, pitch_val,
        output throttle_out, yaw_out, roll_out, pitch_out,
        output armed, failsafe, link_ok
    );
endinterface

// File: rtl/receiver_failsafe.sv
// RC link watchdog and arm/disarm gate between receiver and angle_controller;
// ramps throttle down to zero when the pwm lines go quiet while armed.
module receiver_failsafe #(
    parameter int                           REC_VAL_BIT_WIDTH = 8,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] CENTER            = 8'd127,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] THR_LOW           = 8'd10,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_HIGH          = 8'd230,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_LOW           = 8'd25,
    parameter int                           TIMEOUT_US        = 100000,
    parameter int                           ARM_HOLD_US       = 1000000,
    parameter int                           RAMP_STEP_US      = 4000,
    parameter int                           CNT_W             = 21
) (
    input logic           us_clk,
    input logic           reset,
    receiver_failsafe_if.slave bus
);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        FAILSAFE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(ARM_HOLD_US - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST    = CNT_W'(RAMP_STEP_US - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] VAL_ZERO = '0;
    localparam logic [REC_VAL_BIT_WIDTH-1:0] VAL_ONE  = REC_VAL_BIT_WIDTH'(1);

    logic [3:0]                   pwm_s1;
    logic [3:0]                   pwm_s2;
    logic [3:0]                   pwm_s3;
    logic                         any_edge;
    logic [CNT_W-1:0]             act_cnt;
    logic                         link_ok_q;

    state_t                       state;
    state_t                       state_n;
    logic [CNT_W-1:0]             hold_cnt;
    logic [CNT_W-1:0]             hold_n;
    logic [CNT_W-1:0]             ramp_cnt;
    logic [CNT_W-1:0]             ramp_n;
    logic                         ramp_tick;
    logic                         arm_gesture;
    logic                         disarm_gesture;

    logic [REC_VAL_BIT_WIDTH-1:0] thr_q;
    logic [REC_VAL_BIT_WIDTH-1:0] yaw_q;
    logic [REC_VAL_BIT_WIDTH-1:0] roll_q;
    logic [REC_VAL_BIT_WIDTH-1:0] pitch_q;
    logic [REC_VAL_BIT_WIDTH-1:0] thr_n;
    logic [REC_VAL_BIT_WIDTH-1:0] yaw_n;
    logic [REC_VAL_BIT_WIDTH-1:0] roll_n;
    logic [REC_VAL_BIT_WIDTH-1:0] pitch_n;
    logic                         armed_q;
    logic                         failsafe_q;

    // pwm lines are asynchronous: two sync flops, the third only feeds edge detection
    assign any_edge = |(pwm_s2 & ~pwm_s3);

    always_ff @(posedge us_clk) begin
        if (reset) begin
            pwm_s1    <= '0;
            pwm_s2    <= '0;
            pwm_s3    <= '0;
            act_cnt   <= '0;
            link_ok_q <= 1'b0;
        end else begin
            pwm_s1 <= {bus.throttle_pwm, bus.yaw_pwm, bus.roll_pwm, bus.pitch_pwm};
            pwm_s2 <= pwm_s1;
            pwm_s3 <= pwm_s2;
            if (any_edge) begin
                act_cnt   <= '0;
                link_ok_q <= 1'b1;
            end else if (act_cnt != TIMEOUT_C) begin
                act_cnt <= act_cnt + CNT_ONE;
                if (act_cnt == TIMEOUT_LAST) begin
                    link_ok_q <= 1'b0;
                end
            end
        end
    end

    assign arm_gesture    = link_ok_q && (bus.throttle_val <= THR_LOW) && (bus.yaw_val >= YAW_HIGH);
    assign disarm_gesture = (bus.throttle_val <= THR_LOW) && (bus.yaw_val <= YAW_LOW);

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        ramp_n    = ramp_cnt;
        ramp_tick = 1'b0;
        thr_n     = thr_q;
        yaw_n     = yaw_q;
        roll_n    = roll_q;
        pitch_n   = pitch_q;

        case (state)
            DISARMED: begin
                if (arm_gesture) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = ARMED;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + CNT_ONE;
                    end
                end else begin
                    hold_n = '0;
                end
            end
            ARMED: begin
                // link loss beats a disarm gesture finishing on the same cycle
                if (!link_ok_q) begin
                    state_n = FAILSAFE;
                    hold_n  = '0;
                    ramp_n  = '0;
                end else if (disarm_gesture) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = DISARMED;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + CNT_ONE;
                    end
                end else begin
                    hold_n = '0;
                end
            end
            FAILSAFE: begin
                if (thr_q == VAL_ZERO) begin
                    state_n = DISARMED;
                    hold_n  = '0;
                    ramp_n  = '0;
                end else if (ramp_cnt == RAMP_LAST) begin
                    ramp_n    = '0;
                    ramp_tick = 1'b1;
                end else begin
                    ramp_n = ramp_cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = DISARMED;
                hold_n  = '0;
                ramp_n  = '0;
            end
        endcase

        case (state_n)
            ARMED: begin
                thr_n   = bus.throttle_val;
                yaw_n   = bus.yaw_val;
                roll_n  = bus.roll_val;
                pitch_n = bus.pitch_val;
            end
            FAILSAFE: begin
                thr_n   = ramp_tick ? (thr_q - VAL_ONE) : thr_q;
                yaw_n   = CENTER;
                roll_n  = CENTER;
                pitch_n = CENTER;
            end
            default: begin
                thr_n   = VAL_ZERO;
                yaw_n   = CENTER;
                roll_n  = CENTER;
                pitch_n = CENTER;
            end
        endcase
    end

    always_ff @(posedge us_clk) begin
        if (reset) begin
            state      <= DISARMED;
            hold_cnt   <= '0;
            ramp_cnt   <= '0;
            thr_q      <= VAL_ZERO;
            yaw_q      <= CENTER;
            roll_q     <= CENTER;
            pitch_q    <= CENTER;
            armed_q    <= 1'b0;
            failsafe_q <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            ramp_cnt   <= ramp_n;
            thr_q      <= thr_n;
            yaw_q      <= yaw_n;
            roll_q     <= roll_n;
            pitch_q    <= pitch_n;
            armed_q    <= (state_n == ARMED);
            failsafe_q <= (state_n == FAILSAFE);
        end
    end

    assign bus.throttle_out = thr_q;
    assign bus.yaw_out      = yaw_q;
    assign bus.roll_out     = roll_q;
    assign bus.pitch_out    = pitch_q;
    assign bus.armed        = armed_q;
    assign bus.failsafe     = failsafe_q;
    assign bus.link_ok      = link_ok_q;

endmodule

// File: tb/tb_receiver_failsafe.sv
// Bench for receiver_failsafe: directed gesture/loss scenarios plus random phases,
// every cycle compared against a behavioural model of the failsafe rules.
module tb_receiver_failsafe;

    localparam int W       = 8;
    localparam int TIMEOUT = 100;
    localparam int HOLD    = 50;
    localparam int STEP    = 4;
    localparam int CENTER  = 127;

    logic us_clk = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    receiver_failsafe_if #(.W(W)) bus ();

    receiver_failsafe #(
        .REC_VAL_BIT_WIDTH(W),
        .TIMEOUT_US(TIMEOUT),
        .ARM_HOLD_US(HOLD),
        .RAMP_STEP_US(STEP)
    ) dut (
        .us_clk(us_clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 us_clk = ~us_clk;

    // Model: mode 0 = disarmed, 1 = armed, 2 = ramping down after link loss
    int         m_mode;
    int         m_run;
    int         m_since;
    bit         m_seen;
    int         m_entry;
    int         m_age;
    logic [3:0] m_hist [3];
    int         m_thr;
    int         m_yaw;
    int         m_roll;
    int         m_pitch;

    int thr_set [4] = '{-1, 5, 100, 0};
    int yaw_set [4] = '{-1, 240, 10, 128};

    task automatic modelReset();
        m_mode  = 0;
        m_run   = 0;
        m_since = 0;
        m_seen  = 1'b0;
        m_entry = 0;
        m_age   = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'h0;
        m_thr   = 0;
        m_yaw   = CENTER;
        m_roll  = CENTER;
        m_pitch = CENTER;
    endtask

    task automatic modelStep(input bit rst, input logic [3:0] pwm,
                             input int thr, input int yaw, input int roll, input int pitch);
        bit link_now;
        bit rise;
        if (rst) begin
            modelReset();
            return;
        end
        // a pwm rise becomes visible to the watchdog two samples after it is driven
        rise      = |(m_hist[1] & ~m_hist[2]);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = pwm;
        link_now  = m_seen && (m_since < TIMEOUT);
        if (rise) begin
            m_seen  = 1'b1;
            m_since = 0;
        end else if (m_since < TIMEOUT) begin
            m_since++;
        end

        if (m_mode == 0) begin
            if (link_now && thr <= 10 && yaw >= 230) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_mode = 1;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (m_mode == 1) begin
            if (!link_now) begin
                m_mode  = 2;
                m_run   = 0;
                m_entry = m_thr;
                m_age   = 0;
            end else if (thr <= 10 && yaw <= 25) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_mode = 0;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            m_age++;
            if (m_entry - (m_age - 1) / STEP <= 0) m_mode = 0;
        end

        if (m_mode == 1) begin
            m_thr = thr; m_yaw = yaw; m_roll = roll; m_pitch = pitch;
        end else if (m_mode == 2) begin
            m_thr = m_entry - m_age / STEP;
            if (m_thr < 0) m_thr = 0;
            m_yaw = CENTER; m_roll = CENTER; m_pitch = CENTER;
        end else begin
            m_thr = 0; m_yaw = CENTER; m_roll = CENTER; m_pitch = CENTER;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("throttle_out", bus.throttle_out, m_thr);
        checkOutput("yaw_out", bus.yaw_out, m_yaw);
        checkOutput("roll_out", bus.roll_out, m_roll);
        checkOutput("pitch_out", bus.pitch_out, m_pitch);
        checkOutput("armed", bus.armed, (m_mode == 1));
        checkOutput("failsafe", bus.failsafe, (m_mode == 2));
        checkOutput("link_ok", bus.link_ok, (m_seen && m_since < TIMEOUT));
    endtask

    // act: 0 = silent pwm, 1 = pulse every 20 cycles, 2 = random pwm; thr/yaw < 0 = random
    task automatic applyStimulus(input int n, input int act, input int thr, input int yaw, input bit rst);
        logic [3:0] pwm;
        int t;
        int y;
        int r;
        int p;
        for (int i = 0; i < n; i++) begin
            t = (thr < 0) ? int'($urandom_range(0, 255)) : thr;
            y = (yaw < 0) ? int'($urandom_range(0, 255)) : yaw;
            r = int'($urandom_range(0, 255));
            p = int'($urandom_range(0, 255));
            case (act)
                1:       pwm = (i % 20 == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                2:       pwm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                default: pwm = 4'h0;
            endcase
            {bus.throttle_pwm, bus.yaw_pwm, bus.roll_pwm, bus.pitch_pwm} = pwm;
            bus.throttle_val = 8'(t);
            bus.yaw_val      = 8'(y);
            bus.roll_val     = 8'(r);
            bus.pitch_val    = 8'(p);
            reset            = rst;
            @(posedge us_clk);
            modelStep(rst, pwm, t, y, r, p);
            @(negedge us_clk);
            compareAll();
            cycle++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_throttle"}, bus.throttle_out, 0);
        checkOutput({tag, "_yaw"}, bus.yaw_out, CENTER);
        checkOutput({tag, "_roll"}, bus.roll_out, CENTER);
        checkOutput({tag, "_pitch"}, bus.pitch_out, CENTER);
        checkOutput({tag, "_armed"}, bus.armed, 0);
        checkOutput({tag, "_failsafe"}, bus.failsafe, 0);
        checkOutput({tag, "_link"}, bus.link_ok, 0);
    endtask

    task automatic armFromDisarmed();
        applyStimulus(5, 1, 5, 128, 1'b0);
        applyStimulus(HOLD, 1, 5, 240, 1'b0);
        checkOutput("rearm", bus.armed, 1);
    endtask

    initial begin
        modelReset();
        {bus.throttle_pwm, bus.yaw_pwm, bus.roll_pwm, bus.pitch_pwm} = 4'h0;
        bus.throttle_val = '0;
        bus.yaw_val      = 8'd128;
        bus.roll_val     = 8'd128;
        bus.pitch_val    = 8'd128;
        @(negedge us_clk);

        applyStimulus(2, 0, 0, 128, 1'b1);
        checkResetValues("reset");

        applyStimulus(5, 1, 5, 128, 1'b0);
        checkOutput("link_up", bus.link_ok, 1);
        applyStimulus(HOLD - 1, 1, 5, 240, 1'b0);
        checkOutput("arm_hold_short", bus.armed, 0);
        applyStimulus(1, 1, 5, 240, 1'b0);
        checkOutput("arm_hold_full", bus.armed, 1);
        applyStimulus(1, 1, 200, 128, 1'b0);
        checkOutput("armed_passthru", bus.throttle_out, 200);

        applyStimulus(HOLD - 1, 1, 5, 10, 1'b0);
        checkOutput("disarm_hold_short", bus.armed, 1);
        applyStimulus(1, 1, 5, 10, 1'b0);
        checkOutput("disarm_hold_full", bus.armed, 0);
        checkOutput("disarm_throttle", bus.throttle_out, 0);

        applyStimulus(HOLD - 1, 1, 5, 240, 1'b0);
        applyStimulus(1, 1, 5, 128, 1'b0);
        applyStimulus(HOLD - 1, 1, 5, 240, 1'b0);
        checkOutput("arm_after_break", bus.armed, 0);
        applyStimulus(1, 1, 5, 240, 1'b0);
        checkOutput("arm_fresh_hold", bus.armed, 1);

        applyStimulus(5, 1, 100, 128, 1'b0);
        applyStimulus(99, 0, 100, 128, 1'b0);
        checkOutput("loss_link", bus.link_ok, 0);
        checkOutput("loss_still_armed", bus.armed, 1);
        applyStimulus(1, 0, 100, 128, 1'b0);
        checkOutput("fs_entry", bus.failsafe, 1);
        checkOutput("fs_entry_thr", bus.throttle_out, 100);
        checkOutput("fs_entry_yaw", bus.yaw_out, CENTER);
        applyStimulus(20, 0, 100, 128, 1'b0);
        checkOutput("fs_ramp_thr", bus.throttle_out, 95);
        applyStimulus(380, 0, 100, 128, 1'b0);
        checkOutput("fs_ramp_end_thr", bus.throttle_out, 0);
        checkOutput("fs_ramp_end_state", bus.failsafe, 1);
        applyStimulus(1, 0, 100, 128, 1'b0);
        checkOutput("fs_to_disarmed", bus.failsafe, 0);
        checkOutput("fs_to_disarmed_armed", bus.armed, 0);

        armFromDisarmed();
        applyStimulus(5, 1, 100, 128, 1'b0);
        applyStimulus(150, 0, 100, 128, 1'b0);
        applyStimulus(150, 1, 5, 240, 1'b0);
        checkOutput("recover_link", bus.link_ok, 1);
        checkOutput("recover_still_fs", bus.failsafe, 1);
        checkOutput("recover_no_arm", bus.armed, 0);
        checkOutput("recover_thr", bus.throttle_out, 50);
        applyStimulus(250, 1, 100, 128, 1'b0);
        checkOutput("recover_done_fs", bus.failsafe, 0);
        checkOutput("recover_done_armed", bus.armed, 0);

        // disarm gesture finishing one cycle before, then exactly on, the loss cycle
        for (int k = 49; k <= 50; k++) begin
            armFromDisarmed();
            applyStimulus(5, 1, 100, 128, 1'b0);
            applyStimulus(k, 0, 100, 128, 1'b0);
            applyStimulus(100 - k, 0, 5, 10, 1'b0);
            checkOutput("collide_failsafe", bus.failsafe, (k == 50));
            checkOutput("collide_armed", bus.armed, 0);
        end
        applyStimulus(30, 0, 100, 128, 1'b0);
        applyStimulus(1, 0, 100, 128, 1'b1);
        checkResetValues("reset_mid_ramp");

        for (int it = 0; it < 40; it++) begin
            applyStimulus(int'($urandom_range(1, 120)), int'($urandom_range(0, 2)),
                          thr_set[$urandom_range(0, 3)], yaw_set[$urandom_range(0, 3)],
                          ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
